// File: rtl/level_gen_pkg.sv
// Purpose: shared types and constants for the level_gen edge-to-level generator.
// Latency: n/a (definitions only).
// Backpressure: n/a; requests are never stalled, only deferred or dropped.
package level_gen_pkg;

  localparam logic LVL_LOW  = 1'b0;
  localparam logic LVL_HIGH = 1'b1;

  // STABLE: dwell timer idle, a differing request is applied at once.
  // HOLD: dwell timer running, differing requests park in the pending slot.
  typedef enum logic {
    STABLE = 1'b0,
    HOLD   = 1'b1
  } state_e;

  // One-deep pending slot; target is always the opposite of the current level.
  typedef struct packed {
    logic valid;
    logic target;
  } pend_t;

endpackage

// File: rtl/level_gen_if.sv
// Purpose: request/level bundle between a requester and level_gen.
// Latency: n/a (wires only).
// Backpressure: none; busy_o is advisory. Optional echo outputs under LEVEL_GEN_EDGE_ECHO_EN.
interface level_gen_if;

  logic rise_i;
  logic fall_i;
  logic level_o;
  logic busy_o;
  logic drop_o;
`ifdef LEVEL_GEN_EDGE_ECHO_EN
  logic rising_edge_o;
  logic falling_edge_o;

  modport master (output rise_i, fall_i,
                  input  level_o, busy_o, drop_o, rising_edge_o, falling_edge_o);
  modport slave  (input  rise_i, fall_i,
                  output level_o, busy_o, drop_o, rising_edge_o, falling_edge_o);
`else
  modport master (output rise_i, fall_i,
                  input  level_o, busy_o, drop_o);
  modport slave  (input  rise_i, fall_i,
                  output level_o, busy_o, drop_o);
`endif

endinterface

// File: rtl/level_gen_dwell_timer.sv
// Purpose: down-counter holding off level transitions for MIN_DWELL cycles.
// Latency: load seen next cycle; zero_o is combinational from the count register.
// Backpressure: none; a load always wins over counting, count saturates at 0.
module dwell_timer #(
  parameter int MIN_DWELL = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  output logic zero_o
);

  localparam int            TW       = (MIN_DWELL > 1) ? $clog2(MIN_DWELL) : 1;
  localparam logic [TW-1:0] LOAD_VAL = TW'(MIN_DWELL - 1);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  // Reload on a transition, otherwise count down and stick at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - TW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/level_gen.sv
// Purpose: turn rise/fall request pulses into a registered level with a minimum dwell.
// Latency: accepted request changes level_o one edge later; pending ones on dwell expiry.
// Backpressure: none; requests during a dwell are parked one-deep, collapses/conflicts pulse drop_o.
// Optional: define LEVEL_GEN_EDGE_ECHO_EN to add rising_edge_o/falling_edge_o echo pulses.
module level_gen
  import level_gen_pkg::*;
#(
  parameter int   MIN_DWELL  = 4,
  parameter logic INIT_LEVEL = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  level_gen_if.slave   lg
);

  state_e state_q, state_d;
  pend_t  pend_q,  pend_d;
  logic   level_q, level_d;
  logic   drop_q,  drop_d;
  logic   load;
  logic   timer_zero;

  logic   conflict;
  logic   req;
  logic   tgt;

  // A transition from STABLE only needs a dwell phase when MIN_DWELL exceeds one.
  localparam state_e AFTER_TOGGLE = (MIN_DWELL > 1) ? HOLD : STABLE;

  assign conflict = lg.rise_i & lg.fall_i;
  assign req      = (lg.rise_i | lg.fall_i) & ~conflict;
  assign tgt      = lg.rise_i ? LVL_HIGH : LVL_LOW;

  dwell_timer #(.MIN_DWELL(MIN_DWELL)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load_i (load),
    .zero_o (timer_zero)
  );

  // Next-state: apply, park or collapse requests; expiring pending slot applies before new input.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    level_d = level_q;
    drop_d  = conflict;
    load    = 1'b0;
    unique case (state_q)
      STABLE: begin
        if (req && tgt != level_q) begin
          level_d = tgt;
          load    = 1'b1;
          state_d = AFTER_TOGGLE;
        end
      end
      HOLD: begin
        if (timer_zero && pend_q.valid) begin
          // Pending applies first; the pending slot is then empty for the new request.
          level_d = pend_q.target;
          load    = 1'b1;
          pend_d  = '0;
          if (req && tgt != pend_q.target) begin
            pend_d = '{valid: 1'b1, target: tgt};
          end
        end else if (timer_zero) begin
          // Dwell is over with nothing queued: behave as STABLE this cycle.
          state_d = STABLE;
          if (req && tgt != level_q) begin
            level_d = tgt;
            load    = 1'b1;
            state_d = AFTER_TOGGLE;
          end
        end else if (req) begin
          if (tgt != level_q) begin
            pend_d = '{valid: 1'b1, target: tgt};
          end else if (pend_q.valid) begin
            // Request back to the current level cancels the queued glitch.
            pend_d = '0;
            drop_d = 1'b1;
          end
        end
      end
      default: state_d = STABLE;
    endcase
  end

  // State, level, pending slot and drop registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= STABLE;
      pend_q  <= '0;
      level_q <= INIT_LEVEL;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      level_q <= level_d;
      drop_q  <= drop_d;
    end
  end

  assign lg.level_o = level_q;
  assign lg.busy_o  = (state_q == HOLD);
  assign lg.drop_o  = drop_q;

`ifdef LEVEL_GEN_EDGE_ECHO_EN
  logic rise_echo_q;
  logic fall_echo_q;

  // Echo pulses line up with the first cycle level_o shows its new value.
  always_ff @(posedge clk) begin
    if (reset) begin
      rise_echo_q <= 1'b0;
      fall_echo_q <= 1'b0;
    end else begin
      rise_echo_q <= level_d & ~level_q;
      fall_echo_q <= ~level_d & level_q;
    end
  end

  assign lg.rising_edge_o  = rise_echo_q;
  assign lg.falling_edge_o = fall_echo_q;
`endif

endmodule

// File: tb/tb_level_gen.sv
// Purpose: scenario bench for level_gen with MIN_DWELL=4, INIT_LEVEL=0.
// Latency: cycle c inputs are driven at the falling edge inside cycle c; outputs checked one cycle on.
// Backpressure: n/a.
module tb_level_gen;

  typedef struct packed {
    logic level;
    logic busy;
    logic drop;
  } obs_t;

  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;
  obs_t exp_q[$];

  level_gen_if lg_if ();

  level_gen #(.MIN_DWELL(4), .INIT_LEVEL(1'b0)) dut (
    .clk   (clk),
    .reset (reset),
    .lg    (lg_if)
  );

  always #5 clk = ~clk;

  // Reset held in cycles 0-1 and also pulsed with a rise/fall conflict; everything must stay idle.
  task automatic test_reset();
    obs_t e, g;
    exp_q.delete();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c > 0) begin
        e = exp_q.pop_front();
        g = '{lg_if.level_o, lg_if.busy_o, lg_if.drop_o};
        n_chk++;
        if (g !== e) begin
          n_fail++;
          $display("FAIL reset cyc %0d: got lvl/busy/drop=%b want %b", c, g, e);
        end
      end
      reset = (c < 2);
      lg_if.rise_i = (c == 1);
      lg_if.fall_i = (c == 1);
      exp_q.push_back('{1'b0, 1'b0, 1'b0});
    end
  endtask

  // rise at 5: level 1 from 6, busy 6..9.
  task automatic test_rise();
    obs_t e, g;
    exp_q.delete();
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (c > 0) begin
        e = exp_q.pop_front();
        g = '{lg_if.level_o, lg_if.busy_o, lg_if.drop_o};
        n_chk++;
        if (g !== e) begin
          n_fail++;
          $display("FAIL rise cyc %0d: got lvl/busy/drop=%b want %b", c, g, e);
        end
      end
      reset = (c < 2);
      lg_if.rise_i = (c == 5);
      lg_if.fall_i = 1'b0;
      exp_q.push_back('{(c + 1 >= 6), (c + 1 >= 6 && c + 1 <= 9), 1'b0});
    end
  endtask

  // rise 5, fall 7, fall 8 (same target again): level falls at 10, busy 6..13, never drop.
  task automatic test_pending();
    obs_t e, g;
    exp_q.delete();
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      if (c > 0) begin
        e = exp_q.pop_front();
        g = '{lg_if.level_o, lg_if.busy_o, lg_if.drop_o};
        n_chk++;
        if (g !== e) begin
          n_fail++;
          $display("FAIL pending cyc %0d: got lvl/busy/drop=%b want %b", c, g, e);
        end
      end
      reset = (c < 2);
      lg_if.rise_i = (c == 5);
      lg_if.fall_i = (c == 7 || c == 8);
      exp_q.push_back('{(c + 1 >= 6 && c + 1 <= 9), (c + 1 >= 6 && c + 1 <= 13), 1'b0});
    end
  endtask

  // rise 5, fall 7, rise 8: pending collapses, drop at 9, level stays 1, busy 6..9.
  task automatic test_glitch_collapse();
    obs_t e, g;
    exp_q.delete();
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (c > 0) begin
        e = exp_q.pop_front();
        g = '{lg_if.level_o, lg_if.busy_o, lg_if.drop_o};
        n_chk++;
        if (g !== e) begin
          n_fail++;
          $display("FAIL collapse cyc %0d: got lvl/busy/drop=%b want %b", c, g, e);
        end
      end
      reset = (c < 2);
      lg_if.rise_i = (c == 5 || c == 8);
      lg_if.fall_i = (c == 7);
      exp_q.push_back('{(c + 1 >= 6), (c + 1 >= 6 && c + 1 <= 9), (c + 1 == 9)});
    end
  endtask

  // rise and fall together at 5: drop at 6 only, level and busy stay 0.
  task automatic test_conflict();
    obs_t e, g;
    exp_q.delete();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c > 0) begin
        e = exp_q.pop_front();
        g = '{lg_if.level_o, lg_if.busy_o, lg_if.drop_o};
        n_chk++;
        if (g !== e) begin
          n_fail++;
          $display("FAIL conflict cyc %0d: got lvl/busy/drop=%b want %b", c, g, e);
        end
      end
      reset = (c < 2);
      lg_if.rise_i = (c == 5);
      lg_if.fall_i = (c == 5);
      exp_q.push_back('{1'b0, 1'b0, (c + 1 == 6)});
    end
  endtask

  // rise 5, fall 7, reset 8: back to 0 idle at 9, pending discarded silently.
  task automatic test_reset_mid_dwell();
    obs_t e, g;
    exp_q.delete();
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (c > 0) begin
        e = exp_q.pop_front();
        g = '{lg_if.level_o, lg_if.busy_o, lg_if.drop_o};
        n_chk++;
        if (g !== e) begin
          n_fail++;
          $display("FAIL rst_mid cyc %0d: got lvl/busy/drop=%b want %b", c, g, e);
        end
      end
      reset = (c < 2 || c == 8);
      lg_if.rise_i = (c == 5);
      lg_if.fall_i = (c == 7);
      exp_q.push_back('{(c + 1 >= 6 && c + 1 <= 8), (c + 1 >= 6 && c + 1 <= 8), 1'b0});
    end
  endtask

  // rise 5, rise 7 (same level mid-dwell), rise 12 (same level while stable): all ignored, no drop.
  task automatic test_redundant();
    obs_t e, g;
    exp_q.delete();
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (c > 0) begin
        e = exp_q.pop_front();
        g = '{lg_if.level_o, lg_if.busy_o, lg_if.drop_o};
        n_chk++;
        if (g !== e) begin
          n_fail++;
          $display("FAIL redundant cyc %0d: got lvl/busy/drop=%b want %b", c, g, e);
        end
      end
      reset = (c < 2);
      lg_if.rise_i = (c == 5 || c == 7 || c == 12);
      lg_if.fall_i = 1'b0;
      exp_q.push_back('{(c + 1 >= 6), (c + 1 >= 6 && c + 1 <= 9), 1'b0});
    end
  endtask

  // rise 5, fall 7, rise 9 (expiry cycle): fall applies at 10, rise re-queues and applies at 14.
  task automatic test_back_to_back();
    obs_t e, g;
    exp_q.delete();
    for (int c = 0; c < 21; c++) begin
      @(negedge clk);
      if (c > 0) begin
        e = exp_q.pop_front();
        g = '{lg_if.level_o, lg_if.busy_o, lg_if.drop_o};
        n_chk++;
        if (g !== e) begin
          n_fail++;
          $display("FAIL b2b cyc %0d: got lvl/busy/drop=%b want %b", c, g, e);
        end
      end
      reset = (c < 2);
      lg_if.rise_i = (c == 5 || c == 9);
      lg_if.fall_i = (c == 7);
      exp_q.push_back('{((c + 1 >= 6 && c + 1 <= 9) || c + 1 >= 14),
                        (c + 1 >= 6 && c + 1 <= 17), 1'b0});
    end
  endtask

  // rise 5 then fall 9 exactly at expiry with nothing queued: fall taken at once, visible at 10.
  task automatic test_expiry_accept();
    obs_t e, g;
    exp_q.delete();
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (c > 0) begin
        e = exp_q.pop_front();
        g = '{lg_if.level_o, lg_if.busy_o, lg_if.drop_o};
        n_chk++;
        if (g !== e) begin
          n_fail++;
          $display("FAIL expiry cyc %0d: got lvl/busy/drop=%b want %b", c, g, e);
        end
      end
      reset = (c < 2);
      lg_if.rise_i = (c == 5);
      lg_if.fall_i = (c == 9);
      exp_q.push_back('{(c + 1 >= 6 && c + 1 <= 9), (c + 1 >= 6 && c + 1 <= 13), 1'b0});
    end
  endtask

`ifdef LEVEL_GEN_EDGE_ECHO_EN
  // rise 5, fall 12: rising_edge_o only at 6, falling_edge_o only at 13.
  task automatic test_echo();
    logic [1:0] e, g;
    logic [1:0] eq[$];
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (c > 0) begin
        e = eq.pop_front();
        g = {lg_if.rising_edge_o, lg_if.falling_edge_o};
        n_chk++;
        if (g !== e) begin
          n_fail++;
          $display("FAIL echo cyc %0d: got rise/fall edge=%b want %b", c, g, e);
        end
      end
      reset = (c < 2);
      lg_if.rise_i = (c == 5);
      lg_if.fall_i = (c == 12);
      eq.push_back({(c + 1 == 6), (c + 1 == 13)});
    end
  endtask
`endif

  initial begin
    reset        = 1'b1;
    lg_if.rise_i = 1'b0;
    lg_if.fall_i = 1'b0;
    test_reset();
    test_rise();
    test_pending();
    test_glitch_collapse();
    test_conflict();
    test_reset_mid_dwell();
    test_redundant();
    test_back_to_back();
    test_expiry_accept();
`ifdef LEVEL_GEN_EDGE_ECHO_EN
    test_echo();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
